xadc_drp_reader: RTL and testbench

//   Fetches conversion results from the XADC via its DRP port and presents them as
//   the 16-bit xadc_data word consumed by the voltage averager. Each XADC end-of-conversion

---
 rtl/xadc_drp_reader.sv | 157 +++++++++++++++
 tb/tb_xadc_drp_reader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: issues one DRP read per XADC end-of-conversion pulse and
// publishes the returned word on xadc_data with a one-cycle data_valid strobe.
// A read that gets no drdy within TIMEOUT_CYCLES is abandoned with a timeout
// strobe. One eoc arriving while busy is queued; further ones are counted as
// overruns.
module xadc_drp_reader #(
  parameter logic [6:0] CHANNEL_ADDR    = 7'h03,
  parameter bit         USE_EOC_CHANNEL = 1'b0,
  parameter int         TIMEOUT_CYCLES  = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        eoc,
  input  logic [4:0]  channel,
  input  logic        drdy,
  input  logic [15:0] do_drp,
  output logic        den,
  output logic        dwe,
  output logic [6:0]  daddr,
  output logic [15:0] di_drp,
  output logic [15:0] xadc_data,
  output logic        data_valid,
  output logic        timeout,
  output logic [7:0]  overrun_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // The counter is cleared in REQ and first seen as 0 in the cycle after den,
  // so stopping at TIMEOUT_CYCLES-2 puts the timeout strobe exactly
  // TIMEOUT_CYCLES cycles after the den cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 2);

  logic [1:0]  state_r, state_nx_s;
  logic [7:0]  cnt_r, cnt_nx_s;
  logic        pending_r, pending_nx_s;
  logic [4:0]  pend_ch_r, pend_ch_nx_s;
  logic        den_r, den_nx_s;
  logic [6:0]  daddr_r, daddr_nx_s;
  logic [15:0] data_r, data_nx_s;
  logic        valid_r, valid_nx_s;
  logic        timeout_r, timeout_nx_s;
  logic [7:0]  overrun_r, overrun_nx_s;
  logic        busy_s;

  // DRP address for a read triggered on the given channel.
  function automatic logic [6:0] read_addr(input logic [4:0] ch);
    if (USE_EOC_CHANNEL) begin
      return {2'b00, ch};
    end else begin
      return CHANNEL_ADDR;
    end
  endfunction

  assign busy_s = (state_r == ST_REQ) || (state_r == ST_WAIT);

  // Next-state and next-output computation for the read sequencer.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    pending_nx_s = pending_r;
    pend_ch_nx_s = pend_ch_r;
    den_nx_s     = 1'b0;
    daddr_nx_s   = daddr_r;
    data_nx_s    = data_r;
    valid_nx_s   = 1'b0;
    timeout_nx_s = 1'b0;
    overrun_nx_s = overrun_r;

    case (state_r)
      ST_IDLE: begin
        if (eoc || pending_r) begin
          // A queued request is serviced first; a same-edge eoc re-queues.
          state_nx_s   = ST_REQ;
          den_nx_s     = 1'b1;
          daddr_nx_s   = pending_r ? read_addr(pend_ch_r) : read_addr(channel);
          pending_nx_s = pending_r && eoc;
          pend_ch_nx_s = (pending_r && eoc) ? channel : pend_ch_r;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_nx_s = ST_WAIT;
        cnt_nx_s   = 8'd0;
      end
      ST_WAIT: begin
        if (drdy) begin
          // drdy takes priority over an expiring wait.
          data_nx_s  = do_drp;
          valid_nx_s = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (cnt_r == WAIT_LAST) begin
          timeout_nx_s = 1'b1;
          state_nx_s   = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // eoc while a read is outstanding is queued; a second one is an overrun.
    if (eoc && busy_s) begin
      pending_nx_s = 1'b1;
      pend_ch_nx_s = channel;
      if (pending_r && (overrun_r != 8'hFF)) begin
        overrun_nx_s = overrun_r + 8'd1;
      end else begin
        overrun_nx_s = overrun_r;
      end
    end else begin
      overrun_nx_s = overrun_r;
    end
  end

  // Registered state and outputs with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      pending_r <= 1'b0;
      pend_ch_r <= 5'd0;
      den_r     <= 1'b0;
      daddr_r   <= CHANNEL_ADDR;
      data_r    <= 16'h0000;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      overrun_r <= 8'd0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      pending_r <= pending_nx_s;
      pend_ch_r <= pend_ch_nx_s;
      den_r     <= den_nx_s;
      daddr_r   <= daddr_nx_s;
      data_r    <= data_nx_s;
      valid_r   <= valid_nx_s;
      timeout_r <= timeout_nx_s;
      overrun_r <= overrun_nx_s;
    end
  end

  assign den         = den_r;
  assign dwe         = 1'b0;
  assign daddr       = daddr_r;
  assign di_drp      = 16'h0000;
  assign xadc_data   = data_r;
  assign data_valid  = valid_r;
  assign timeout     = timeout_r;
  assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Scoreboard bench: instance A uses the fixed status address, instance B the
// eoc channel. Stimulus pushes expected results; negedge monitors pop/compare.
module tb_xadc_drp_reader;

  localparam int TO = 10;

  logic        clock, reset;
  logic        eoc_a, drdy_a, eoc_b, drdy_b;
  logic [4:0]  channel_a, channel_b;
  logic [15:0] do_a, do_b;
  logic        den_a, dwe_a, dv_a, to_a, den_b, dwe_b, dv_b, to_b;
  logic [6:0]  daddr_a, daddr_b;
  logic [15:0] di_a, di_b, xd_a, xd_b;
  logic [7:0]  ovr_a, ovr_b;

  typedef struct packed {
    logic        is_to;
    logic [15:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int den_cnt_a = 0;

  xadc_drp_reader #(.CHANNEL_ADDR(7'h03), .USE_EOC_CHANNEL(1'b0), .TIMEOUT_CYCLES(TO)) dut_a (
    .clock(clock), .reset(reset), .eoc(eoc_a), .channel(channel_a), .drdy(drdy_a),
    .do_drp(do_a), .den(den_a), .dwe(dwe_a), .daddr(daddr_a), .di_drp(di_a),
    .xadc_data(xd_a), .data_valid(dv_a), .timeout(to_a), .overrun_cnt(ovr_a));

  xadc_drp_reader #(.CHANNEL_ADDR(7'h03), .USE_EOC_CHANNEL(1'b1), .TIMEOUT_CYCLES(TO)) dut_b (
    .clock(clock), .reset(reset), .eoc(eoc_b), .channel(channel_b), .drdy(drdy_b),
    .do_drp(do_b), .den(den_b), .dwe(dwe_b), .daddr(daddr_b), .di_drp(di_b),
    .xadc_data(xd_b), .data_valid(dv_b), .timeout(to_b), .overrun_cnt(ovr_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Invariants and den counting.
  always @(negedge clock) begin
    chk("dwe_a_zero", {31'd0, dwe_a}, 32'd0);
    chk("di_a_zero", {16'd0, di_a}, 32'd0);
    chk("dv_to_excl_a", {31'd0, dv_a & to_a}, 32'd0);
    chk("dwe_b_zero", {31'd0, dwe_b}, 32'd0);
    chk("di_b_zero", {16'd0, di_b}, 32'd0);
    chk("dv_to_excl_b", {31'd0, dv_b & to_b}, 32'd0);
    if (den_a) den_cnt_a++;
  end

  // Scoreboard monitor, instance A.
  always @(negedge clock) begin
    exp_t e;
    if (dv_a || to_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_event_a", {15'd0, to_a, xd_a}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        chk("sb_kind_a", {31'd0, to_a}, {31'd0, e.is_to});
        chk("sb_data_a", {16'd0, xd_a}, {16'd0, e.data});
      end
    end
  end

  // Scoreboard monitor, instance B.
  always @(negedge clock) begin
    exp_t e;
    if (dv_b || to_b) begin
      if (q_b.size() == 0) begin
        chk("unexpected_event_b", {15'd0, to_b, xd_b}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        chk("sb_kind_b", {31'd0, to_b}, {31'd0, e.is_to});
        chk("sb_data_b", {16'd0, xd_b}, {16'd0, e.data});
      end
    end
  end

  // Wait (bounded) for den on one instance; returns at the negedge where it is seen.
  task automatic wait_den(input bit use_b, output int c);
    bit found = 1'b0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if ((use_b ? den_b : den_a) === 1'b1) begin
        found = 1'b1;
        c = cyc;
        break;
      end
    end
    if (!found) chk("den_wait_expired", 32'd0, 32'd1);
  endtask

  // One eoc pulse on instance A, then wait for its den.
  task automatic start_read_a(output int c);
    eoc_a = 1'b1;
    @(posedge clock); #1 eoc_a = 1'b0;
    wait_den(1'b0, c);
  endtask

  initial begin
    int c0, c1, base;
    bit seen;
    reset = 1'b1;
    eoc_a = 1'b0; drdy_a = 1'b0; channel_a = 5'h07; do_a = 16'h0000;
    eoc_b = 1'b0; drdy_b = 1'b0; channel_b = 5'h00; do_b = 16'h0000;

    // 1: reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_den", {31'd0, den_a}, 32'd0);
    chk("rst_daddr_a", {25'd0, daddr_a}, 32'h03);
    chk("rst_daddr_b", {25'd0, daddr_b}, 32'h03);
    chk("rst_data", {16'd0, xd_a}, 32'd0);
    chk("rst_dv", {31'd0, dv_a}, 32'd0);
    chk("rst_to", {31'd0, to_a}, 32'd0);
    chk("rst_ovr", {24'd0, ovr_a}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // 2: single read, fixed address, drdy 3 cycles after den
    start_read_a(c0);
    chk("t2_daddr", {25'd0, daddr_a}, 32'h03);
    @(negedge clock);
    chk("t2_den_one_cycle", {31'd0, den_a}, 32'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    drdy_a = 1'b1; do_a = 16'hABC0;
    q_a.push_back('{is_to: 1'b0, data: 16'hABC0});
    @(posedge clock); #1 drdy_a = 1'b0;
    @(negedge clock);
    chk("t2_dv_latency", {31'd0, dv_a}, 32'd1);
    chk("t2_data", {16'd0, xd_a}, 32'hABC0);
    @(negedge clock);
    chk("t2_dv_pulse", {31'd0, dv_a}, 32'd0);

    // 3: channel mode on instance B
    @(posedge clock); #1;
    channel_b = 5'h10; eoc_b = 1'b1;
    @(posedge clock); #1 eoc_b = 1'b0; channel_b = 5'h02;
    wait_den(1'b1, c0);
    chk("t3_daddr_den", {25'd0, daddr_b}, 32'h10);
    @(negedge clock);
    chk("t3_daddr_wait", {25'd0, daddr_b}, 32'h10);
    @(posedge clock); #1 drdy_b = 1'b1; do_b = 16'h0F00;
    q_b.push_back('{is_to: 1'b0, data: 16'h0F00});
    @(posedge clock); #1 drdy_b = 1'b0;
    @(negedge clock);
    chk("t3_data", {16'd0, xd_b}, 32'h0F00);
    chk("t3_daddr_end", {25'd0, daddr_b}, 32'h10);

    // 4: timeout, then a successful read
    @(posedge clock); #1;
    q_a.push_back('{is_to: 1'b1, data: 16'hABC0});
    start_read_a(c0);
    seen = 1'b0; c1 = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clock);
      if (to_a) begin seen = 1'b1; c1 = cyc; break; end
    end
    chk("t4_timeout_seen", {31'd0, seen}, 32'd1);
    chk("t4_timeout_delay", c1 - c0, TO);
    chk("t4_data_kept", {16'd0, xd_a}, 32'hABC0);
    @(negedge clock);
    chk("t4_timeout_pulse", {31'd0, to_a}, 32'd0);
    @(posedge clock); #1;
    start_read_a(c0);
    @(posedge clock); #1 drdy_a = 1'b1; do_a = 16'h1234;
    q_a.push_back('{is_to: 1'b0, data: 16'h1234});
    @(posedge clock); #1 drdy_a = 1'b0;
    @(negedge clock);
    chk("t4_recover_data", {16'd0, xd_a}, 32'h1234);

    // 5: three eoc pulses during one read
    @(posedge clock); #1;
    base = den_cnt_a;
    start_read_a(c0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1 eoc_a = 1'b1;
      @(posedge clock); #1 eoc_a = 1'b0;
    end
    drdy_a = 1'b1; do_a = 16'h5550;
    q_a.push_back('{is_to: 1'b0, data: 16'h5550});
    @(posedge clock); #1 drdy_a = 1'b0;
    @(negedge clock);
    chk("t5_dv", {31'd0, dv_a}, 32'd1);
    chk("t5_overrun", {24'd0, ovr_a}, 32'd2);
    @(negedge clock);
    chk("t5_followup_den", {31'd0, den_a}, 32'd1);
    @(posedge clock); #1 drdy_a = 1'b1; do_a = 16'h6660;
    q_a.push_back('{is_to: 1'b0, data: 16'h6660});
    @(posedge clock); #1 drdy_a = 1'b0;
    repeat (5) @(negedge clock);
    chk("t5_den_count", den_cnt_a - base, 2);
    chk("t5_data", {16'd0, xd_a}, 32'h6660);
    chk("t5_overrun_hold", {24'd0, ovr_a}, 32'd2);

    // 6: async reset during WAIT, late drdy afterwards
    @(posedge clock); #1;
    start_read_a(c0);
    @(posedge clock); #2 reset = 1'b1;
    #1;
    chk("t6_den", {31'd0, den_a}, 32'd0);
    chk("t6_data_cleared", {16'd0, xd_a}, 32'd0);
    chk("t6_ovr_cleared", {24'd0, ovr_a}, 32'd0);
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1 drdy_a = 1'b1; do_a = 16'hDEAD;
    @(posedge clock); #1 drdy_a = 1'b0;
    @(negedge clock);
    chk("t6_no_dv", {31'd0, dv_a}, 32'd0);
    chk("t6_data_zero", {16'd0, xd_a}, 32'd0);
    @(posedge clock); #1 eoc_a = 1'b1;
    @(posedge clock); #1 eoc_a = 1'b0;
    @(negedge clock);
    chk("t6_idle_den", {31'd0, den_a}, 32'd1);
    @(posedge clock); #1 drdy_a = 1'b1; do_a = 16'h7770;
    q_a.push_back('{is_to: 1'b0, data: 16'h7770});
    @(posedge clock); #1 drdy_a = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_final_data", {16'd0, xd_a}, 32'h7770);

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
